// File: rtl/dmem_lsu_if.sv
// Load/store bus between the datapath and dmem_lsu.
// The datapath drives the request side; the memory returns data, ready and misaligned.
interface dmem_lsu_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic [ADDR_W-1:0] addr;
  logic [31:0]       writeData;
  logic              memWrite;
  logic              memRead;
  logic [1:0]        size;
  logic              unsignedLoad;
  logic [31:0]       readData;
  logic              ready;
  logic              misaligned;

  modport master (
    output addr, writeData, memWrite, memRead, size, unsignedLoad,
    input  readData, ready, misaligned
  );

  modport slave (
    input  addr, writeData, memWrite, memRead, size, unsignedLoad,
    output readData, ready, misaligned
  );
endinterface

// File: rtl/dmem_lsu.sv
// Data memory with byte/half/word access, sign/zero extension and LATENCY wait states.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned accesses; otherwise addresses are force-aligned.
module dmem_lsu #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 1
) (
  input  logic       clock,
  input  logic       rst,
  dmem_lsu_if.slave  bus
);
  localparam int unsigned Words = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              write_q;

  logic [31:0] rdata_q;
  logic        mis_q;

  logic [31:0] mem [Words];

  logic              req;
  logic              accept;
  logic              fire;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [1:0]        acc_size;
  logic              acc_uns;
  logic              acc_write;
  logic              acc_mis;
  logic [1:0]        lane;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic [31:0]       rword;
  logic [15:0]       field;
  logic [31:0]       ext;

  // Address bits above the array are ignored, so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr[ADDR_W-1:DEPTH_LOG2+2];

  assign req    = bus.memRead | bus.memWrite;
  assign accept = (state_q == StIdle) && req;

  // With no wait states the access happens on the accept edge, straight from the bus.
  always_comb begin
    if (LATENCY == 0) begin
      acc_addr  = bus.addr;
      acc_wdata = bus.writeData;
      acc_size  = bus.size;
      acc_uns   = bus.unsignedLoad;
      acc_write = bus.memWrite;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
      acc_uns   = uns_q;
      acc_write = write_q;
    end
  end

  assign fire = !rst && (((LATENCY == 0) && accept) ||
                         ((state_q == StWait) && (cnt_q == 4'd0)));

  always_comb begin
    lane    = acc_addr[1:0];
    acc_mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    unique case (acc_size)
      2'b01:   acc_mis = lane[0];
      2'b10:   acc_mis = (lane != 2'b00);
      2'b11:   acc_mis = 1'b1;
      default: acc_mis = 1'b0;
    endcase
`else
    unique case (acc_size)
      2'b01:   lane = {acc_addr[1], 1'b0};
      2'b10,
      2'b11:   lane = 2'b00;
      default: lane = acc_addr[1:0];
    endcase
`endif
  end

  assign idx = acc_addr[DEPTH_LOG2+1:2];

  // Store lane enables; data is replicated so any enabled lane sees the right bytes.
  always_comb begin
    be    = 4'b1111;
    wword = acc_wdata;
    unique case (acc_size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{acc_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = acc_wdata;
      end
    endcase
  end

  always_comb begin
    rword = mem[idx];
    field = 16'(rword >> {lane, 3'b000});
    ext   = rword;
    unique case (acc_size)
      2'b00:   ext = {{24{~acc_uns & field[7]}}, field[7:0]};
      2'b01:   ext = {{16{~acc_uns & field[15]}}, field[15:0]};
      default: ext = rword;
    endcase
  end

  // Array contents survive reset.
  always_ff @(posedge clock) begin
    if (fire && acc_write && !acc_mis) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wword[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q  <= bus.addr;
      wdata_q <= bus.writeData;
      size_q  <= bus.size;
      uns_q   <= bus.unsignedLoad;
      write_q <= bus.memWrite;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fire) begin
        mis_q <= acc_mis;
        // A store wins over a simultaneous load and leaves readData alone.
        if (!acc_write) rdata_q <= acc_mis ? 32'd0 : ext;
      end
    end
  end

  assign bus.ready      = (state_q == StResp);
  assign bus.misaligned = (state_q == StResp) && mis_q;
  assign bus.readData   = rdata_q;
endmodule
